// File: rtl/aqms_esp_io.sv
// Z80 I/O responder bridging a two-port CTRL/STATUS + DATA window to the ESP32 UART FIFOs.
// Registered outputs only; read data is latched at the strobe and driven until the bus cycle ends.
module aqms_esp_io #(
   parameter logic [7:0] BASE_ADDR = 8'hF4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] ebus_a,
   input  logic [7:0] ebus_d_in,
   input  logic       ebus_rd_n,
   input  logic       ebus_wr_n,
   input  logic       ebus_iorq_n,
   input  logic       ebus_stb,
   output logic [7:0] ebus_d_out,
   output logic       ebus_d_oe,
   output logic [8:0] esp_tx_data,
   output logic       esp_tx_wr,
   input  logic       esp_tx_fifo_full,
   input  logic [8:0] esp_rx_data,
   output logic       esp_rx_rd,
   input  logic       esp_rx_empty,
   input  logic       esp_rx_fifo_overflow,
   input  logic       esp_rx_framing_error
);

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t     state, state_nxt;
   logic       drive;
   logic       hit, rd_hit, wr_hit, is_data;
   logic       clr_rx_ovf, clr_rx_ferr, clr_tx_ovf, set_tx_ovf;
   logic       rx_ovf, rx_ferr, tx_ovf, sof_pending;
   logic [7:0] rd_reg, status;

   // Strobes that land while the previous read is still being driven are dropped.
   assign hit     = ebus_stb && !ebus_iorq_n && (ebus_a[7:1] == BASE_ADDR[7:1]) && (state == IDLE);
   assign rd_hit  = hit && !ebus_rd_n;
   assign wr_hit  = hit && ebus_rd_n && !ebus_wr_n;
   assign is_data = ebus_a[0];

   assign status = {esp_rx_data[8], 2'b00, tx_ovf, rx_ferr, rx_ovf, esp_tx_fifo_full, !esp_rx_empty};

   assign clr_rx_ovf  = wr_hit && !is_data && ebus_d_in[2];
   assign clr_rx_ferr = wr_hit && !is_data && ebus_d_in[3];
   assign clr_tx_ovf  = wr_hit && !is_data && ebus_d_in[4];
   assign set_tx_ovf  = wr_hit && is_data && esp_tx_fifo_full;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_nxt = state;
      drive     = 1'b0;
      case (state)
         IDLE:  if (rd_hit) state_nxt = DRIVE;
         DRIVE: begin
            drive = 1'b1;
            if (ebus_rd_n || ebus_iorq_n) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ebus_d_oe  = drive;
   assign ebus_d_out = rd_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         rd_reg      <= 8'h00;
         esp_tx_data <= 9'h000;
         esp_tx_wr   <= 1'b0;
         esp_rx_rd   <= 1'b0;
         rx_ovf      <= 1'b0;
         rx_ferr     <= 1'b0;
         tx_ovf      <= 1'b0;
         sof_pending <= 1'b0;
      end else begin
         esp_tx_wr <= 1'b0;
         esp_rx_rd <= 1'b0;

         if (rd_hit) begin
            if (is_data) rd_reg <= esp_rx_empty ? 8'h00 : esp_rx_data[7:0];
            else         rd_reg <= status;
            esp_rx_rd <= is_data && !esp_rx_empty;
         end

         if (wr_hit && is_data && !esp_tx_fifo_full) begin
            esp_tx_data <= {sof_pending, ebus_d_in};
            esp_tx_wr   <= 1'b1;
            sof_pending <= 1'b0;
         end else if (wr_hit && !is_data) begin
            sof_pending <= ebus_d_in[7];
         end

         // Set terms sit outside the clear mask so a coincident event survives the clear.
         rx_ovf  <= (rx_ovf  && !clr_rx_ovf)  || esp_rx_fifo_overflow;
         rx_ferr <= (rx_ferr && !clr_rx_ferr) || esp_rx_framing_error;
         tx_ovf  <= (tx_ovf  && !clr_tx_ovf)  || set_tx_ovf;
      end
   end

endmodule

// File: tb/tb_aqms_esp_io.sv
// Directed bench for aqms_esp_io: bus read/write tasks on the falling clock edge,
// hand-computed expectations for STATUS, DATA, TX push, RX pop and sticky flags.
module tb_aqms_esp_io;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] ebus_a, ebus_d_in, ebus_d_out;
   logic       ebus_rd_n, ebus_wr_n, ebus_iorq_n, ebus_stb, ebus_d_oe;
   logic [8:0] esp_tx_data, esp_rx_data;
   logic       esp_tx_wr, esp_tx_fifo_full, esp_rx_rd, esp_rx_empty;
   logic       esp_rx_fifo_overflow, esp_rx_framing_error;

   int n_cmp = 0;
   int n_err = 0;
   int tx_cnt = 0;
   int rx_cnt = 0;

   always #5 clk = ~clk;

   aqms_esp_io #(.BASE_ADDR(8'hF4)) dut (
      .clk(clk), .reset(reset),
      .ebus_a(ebus_a), .ebus_d_in(ebus_d_in),
      .ebus_rd_n(ebus_rd_n), .ebus_wr_n(ebus_wr_n), .ebus_iorq_n(ebus_iorq_n), .ebus_stb(ebus_stb),
      .ebus_d_out(ebus_d_out), .ebus_d_oe(ebus_d_oe),
      .esp_tx_data(esp_tx_data), .esp_tx_wr(esp_tx_wr), .esp_tx_fifo_full(esp_tx_fifo_full),
      .esp_rx_data(esp_rx_data), .esp_rx_rd(esp_rx_rd), .esp_rx_empty(esp_rx_empty),
      .esp_rx_fifo_overflow(esp_rx_fifo_overflow), .esp_rx_framing_error(esp_rx_framing_error)
   );

   always @(posedge clk) begin
      if (esp_tx_wr) tx_cnt <= tx_cnt + 1;
      if (esp_rx_rd) rx_cnt <= rx_cnt + 1;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Full read bus cycle; checks oe framing and returns the data and pop pulse seen at strobe+1.
   task automatic io_read(input logic [7:0] addr, input logic exp_oe, input string tag,
                          output logic [7:0] data, output logic pop);
      @(negedge clk);
      ebus_a = addr; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0; ebus_stb = 1'b1;
      @(negedge clk);
      ebus_stb = 1'b0;
      check({tag, "_oe_s1"}, 16'(ebus_d_oe), 16'(exp_oe));
      data = ebus_d_out;
      pop  = esp_rx_rd;
      @(negedge clk);
      check({tag, "_oe_hold"}, 16'(ebus_d_oe), 16'(exp_oe));
      check({tag, "_rd_once"}, 16'(esp_rx_rd), 16'h0);
      ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
      @(negedge clk);
      check({tag, "_oe_off"}, 16'(ebus_d_oe), 16'h0);
      @(negedge clk);
   endtask

   task automatic io_write(input logic [7:0] addr, input logic [7:0] data, input logic ovf,
                           input logic iorq_n, output logic push, output logic [8:0] word);
      @(negedge clk);
      ebus_a = addr; ebus_d_in = data; ebus_iorq_n = iorq_n; ebus_wr_n = 1'b0; ebus_stb = 1'b1;
      esp_rx_fifo_overflow = ovf;
      @(negedge clk);
      ebus_stb = 1'b0; esp_rx_fifo_overflow = 1'b0;
      push = esp_tx_wr;
      word = esp_tx_data;
      @(negedge clk);
      ebus_wr_n = 1'b1; ebus_iorq_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] d;
      logic       p;
      logic [8:0] w;
      int         t0, r0;

      reset = 1'b1;
      ebus_a = 8'h00; ebus_d_in = 8'h00; ebus_rd_n = 1'b1; ebus_wr_n = 1'b1;
      ebus_iorq_n = 1'b1; ebus_stb = 1'b0;
      esp_tx_fifo_full = 1'b0; esp_rx_data = 9'h000; esp_rx_empty = 1'b1;
      esp_rx_fifo_overflow = 1'b0; esp_rx_framing_error = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_oe", 16'(ebus_d_oe), 16'h0);
      check("rst_dout", 16'(ebus_d_out), 16'h00);
      check("rst_txwr", 16'(esp_tx_wr), 16'h0);
      check("rst_rxrd", 16'(esp_rx_rd), 16'h0);
      check("rst_txdata", 16'(esp_tx_data), 16'h000);

      // 1: STATUS with everything idle
      r0 = rx_cnt;
      io_read(8'hF4, 1'b1, "t1", d, p);
      check("t1_status", 16'(d), 16'h00);
      check("t1_nopop", 16'(rx_cnt - r0), 16'h0);

      // 2: RX head 9'h1A5
      esp_rx_data = 9'h1A5; esp_rx_empty = 1'b0;
      r0 = rx_cnt;
      io_read(8'hF4, 1'b1, "t2s", d, p);
      check("t2_status", 16'(d), 16'h81);
      check("t2_status_nopop", 16'(rx_cnt - r0), 16'h0);
      io_read(8'hF5, 1'b1, "t2d", d, p);
      check("t2_data", 16'(d), 16'hA5);
      check("t2_pop_s1", 16'(p), 16'h1);
      check("t2_pop_cnt", 16'(rx_cnt - r0), 16'h1);
      esp_rx_data = 9'h000; esp_rx_empty = 1'b1;
      r0 = rx_cnt;
      io_read(8'hF5, 1'b1, "t2e", d, p);
      check("t2_empty_data", 16'(d), 16'h00);
      check("t2_empty_nopop", 16'(rx_cnt - r0), 16'h0);

      // 3: start-of-message marker then plain byte
      t0 = tx_cnt;
      io_write(8'hF4, 8'h80, 1'b0, 1'b0, p, w);
      check("t3_ctrl_nopush", 16'(tx_cnt - t0), 16'h0);
      io_write(8'hF5, 8'h3C, 1'b0, 1'b0, p, w);
      check("t3_push1", 16'(p), 16'h1);
      check("t3_word1", 16'(w), 16'h13C);
      io_write(8'hF5, 8'h3D, 1'b0, 1'b0, p, w);
      check("t3_word2", 16'(w), 16'h03D);
      check("t3_cnt", 16'(tx_cnt - t0), 16'h2);

      // 4: TX full drops the byte and sets tx_ovf
      esp_tx_fifo_full = 1'b1;
      t0 = tx_cnt;
      io_write(8'hF5, 8'h55, 1'b0, 1'b0, p, w);
      check("t4_nopush", 16'(tx_cnt - t0), 16'h0);
      io_read(8'hF4, 1'b1, "t4a", d, p);
      check("t4_status_ovf", 16'(d), 16'h12);
      io_write(8'hF4, 8'h10, 1'b0, 1'b0, p, w);
      io_read(8'hF4, 1'b1, "t4b", d, p);
      check("t4_status_clr", 16'(d), 16'h02);
      esp_tx_fifo_full = 1'b0;

      // 5: set beats clear on rx_ovf
      @(negedge clk); esp_rx_fifo_overflow = 1'b1;
      @(negedge clk); esp_rx_fifo_overflow = 1'b0;
      io_read(8'hF4, 1'b1, "t5a", d, p);
      check("t5_set", 16'(d), 16'h04);
      io_write(8'hF4, 8'h04, 1'b1, 1'b0, p, w);
      io_read(8'hF4, 1'b1, "t5b", d, p);
      check("t5_set_wins", 16'(d), 16'h04);
      io_write(8'hF4, 8'h04, 1'b0, 1'b0, p, w);
      io_read(8'hF4, 1'b1, "t5c", d, p);
      check("t5_cleared", 16'(d), 16'h00);

      // 6: out-of-window read, write with IORQ# high, reset mid-DRIVE
      esp_rx_data = 9'h1A5; esp_rx_empty = 1'b0;
      r0 = rx_cnt; t0 = tx_cnt;
      io_read(8'hF6, 1'b0, "t6a", d, p);
      check("t6_f6_nopop", 16'(rx_cnt - r0), 16'h0);
      io_write(8'hF5, 8'h77, 1'b0, 1'b1, p, w);
      check("t6_iorq_nopush", 16'(tx_cnt - t0), 16'h0);
      esp_rx_data = 9'h000; esp_rx_empty = 1'b1;

      esp_tx_fifo_full = 1'b1;
      io_write(8'hF5, 8'h11, 1'b0, 1'b0, p, w);
      esp_tx_fifo_full = 1'b0;
      io_write(8'hF4, 8'h80, 1'b0, 1'b0, p, w);
      @(negedge clk); esp_rx_framing_error = 1'b1;
      @(negedge clk); esp_rx_framing_error = 1'b0;
      io_read(8'hF4, 1'b1, "t6s", d, p);
      check("t6_flags_before", 16'(d), 16'h18);

      @(negedge clk);
      ebus_a = 8'hF4; ebus_iorq_n = 1'b0; ebus_rd_n = 1'b0; ebus_stb = 1'b1;
      @(negedge clk);
      ebus_stb = 1'b0;
      check("t6_drive", 16'(ebus_d_oe), 16'h1);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_oe", 16'(ebus_d_oe), 16'h0);
      reset = 1'b0;
      ebus_rd_n = 1'b1; ebus_iorq_n = 1'b1;
      @(negedge clk);
      io_read(8'hF4, 1'b1, "t6r", d, p);
      check("t6_flags_cleared", 16'(d), 16'h00);
      io_write(8'hF5, 8'hAA, 1'b0, 1'b0, p, w);
      check("t6_sof_cleared", 16'(w), 16'h0AA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aqms_esp_io.md
# aqms_esp_io

Z80 I/O-port responder that bridges bus cycles from the CPU (T80 or external Z80) to the ESP32 UART FIFOs. It sits inside the core-common logic. It decodes IORQ read/write strobes at a two-port window and presents a status/control register and a data register. It drives the external data bus on reads, pushes TX bytes and pops RX bytes with single-cycle pulses, and keeps sticky error flags.

## Interface
Parameters:
- BASE_ADDR, 8'hF4: I/O base. Offset 0 is CTRL/STATUS, offset 1 is DATA. Decoding uses ebus_a[7:1] == BASE_ADDR[7:1].

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock, 28.63636 MHz.
- reset  in  1  synchronous, active-high.
- ebus_a  in  8  low byte of the Z80 address bus.
- ebus_d_in  in  8  write data, registered upstream while WR# is low.
- ebus_rd_n  in  1  Z80 RD#.
- ebus_wr_n  in  1  Z80 WR#.
- ebus_iorq_n  in  1  Z80 IORQ#.
- ebus_stb  in  1  one-cycle pulse on the synchronized falling edge of RD# or WR#.
- ebus_d_out  out  8  read data.
- ebus_d_oe  out  1  drive enable for ebus_d.
- esp_tx_data  out  9  TX word: {start-of-message, byte}.
- esp_tx_wr  out  1  TX FIFO push pulse.
- esp_tx_fifo_full  in  1  TX FIFO full.
- esp_rx_data  in  9  RX FIFO head: {start-of-message, byte}.
- esp_rx_rd  out  1  RX FIFO pop pulse.
- esp_rx_empty  in  1  RX FIFO empty.
- esp_rx_fifo_overflow  in  1  overflow event; sampled every cycle.
- esp_rx_framing_error  in  1  framing-error event; sampled every cycle.

## Operation
Register hit:
- Hit = ebus_stb && !ebus_iorq_n && address match.
- Read or write is selected by !ebus_rd_n or !ebus_wr_n at the strobe cycle.
- A strobe with neither RD# nor WR# low is ignored.

STATUS read, offset 0:
- bit0 = !esp_rx_empty
- bit1 = esp_tx_fifo_full
- bit2 = rx_ovf sticky flag
- bit3 = rx_ferr sticky flag
- bit4 = tx_ovf sticky flag
- bit6:5 = 0
- bit7 = esp_rx_data[8]

CTRL write, offset 0:
- bit2, bit3, bit4: writing 1 clears the corresponding sticky flag.
- bit7: loads sof_pending.
- Other bits are ignored.

DATA read, offset 1:
- If the RX FIFO is non-empty: returns esp_rx_data[7:0] and pops the FIFO.
- If the RX FIFO is empty: returns 8'h00 and does not pop.

DATA write, offset 1:
- If the TX FIFO is not full: pushes {sof_pending, ebus_d_in}, then clears sof_pending.
- If the TX FIFO is full: drops the byte, sets tx_ovf, and leaves sof_pending unchanged.

Sticky flags:
- rx_ovf is ORed with esp_rx_fifo_overflow every cycle; rx_ferr likewise with esp_rx_framing_error.
- When a set and a clear fall in the same cycle, the set wins.

Read state machine:
- IDLE: on a read hit, latch rd_reg (the status or data value at that cycle) and go to DRIVE.
- DRIVE: ebus_d_oe = 1 and ebus_d_out = rd_reg. Return to IDLE in the first cycle where ebus_rd_n or ebus_iorq_n is sampled high.
- Strobes arriving while in DRIVE are ignored.

## Timing
- Reset values: ebus_d_oe = 0, ebus_d_out = 8'h00, esp_tx_wr = 0, esp_rx_rd = 0, esp_tx_data = 9'h000. All sticky flags and sof_pending are 0. State is IDLE.
- Read: ebus_d_oe rises at strobe cycle + 1 and falls 1 cycle after RD# or IORQ# is sampled high.
- DATA read pop: esp_rx_rd is a one-cycle pulse at strobe + 1. The value was already latched at the strobe, so a FIFO head change cannot corrupt the returned data.
- DATA write push: esp_tx_data is registered at strobe and esp_tx_wr pulses at strobe + 1, one cycle only. Full is evaluated at the strobe cycle.
- Pulse guarantee: at most one esp_tx_wr or esp_rx_rd pulse per bus cycle.
- Strobe spacing: strobes are at least 4 clk apart, which the Z80 bus guarantees.
- Reset mid-read: ebus_d_oe drops in the cycle after reset is sampled, and pending pulses are cancelled.
- Combinational timing: no combinational path from any input to any output.

## Test plan
1. Reset, then read STATUS with an empty RX FIFO and a non-full TX FIFO -> 8'h00 is returned, ebus_d_oe is high from strobe + 1 until RD# rises + 1, and no esp_rx_rd pulse occurs.
2. RX FIFO holds 9'h1A5; read DATA at 0xF5 -> 8'hA5 is returned, esp_rx_rd pulses once at strobe + 1, and a STATUS read beforehand shows bit7 = 1 and bit0 = 1.
3. Write CTRL 8'h80, then DATA 8'h3C, then DATA 8'h3D -> esp_tx_data is 9'h13C and then 9'h03D, with one esp_tx_wr pulse each.
4. With esp_tx_fifo_full = 1, write DATA 8'h55 -> no esp_tx_wr pulse and STATUS = 8'h12. Then write CTRL 8'h10 -> STATUS = 8'h02.
5. Pulse esp_rx_fifo_overflow in the same cycle as a CTRL 8'h04 write is registered -> the flag stays set, STATUS bit2 = 1. A second clear write -> bit2 = 0.
6. Read at 0xF6, a write with IORQ# high, and assertion of reset mid-DRIVE -> the first two produce no oe and no pulses; the reset drops ebus_d_oe the next cycle and clears all flags.
